// File: rtl/simple_bus.sv
// Multi-host, multi-device single-cycle bus: fixed-priority arbitration, mask/base decode,
// one-cycle pipelined response. Define SIMPLE_BUS_DECERR_EN to flag unmapped accesses with err=1.
module simple_bus #(
    parameter int NrDevices    = 1,
    parameter int NrHosts      = 1,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    host_req_i     [NrHosts],
    output logic                    host_gnt_o     [NrHosts],
    input  logic [AddressWidth-1:0] host_addr_i    [NrHosts],
    input  logic                    host_we_i      [NrHosts],
    input  logic [DataWidth/8-1:0]  host_be_i      [NrHosts],
    input  logic [DataWidth-1:0]    host_wdata_i   [NrHosts],
    output logic                    host_rvalid_o  [NrHosts],
    output logic [DataWidth-1:0]    host_rdata_o   [NrHosts],
    output logic                    host_err_o     [NrHosts],

    output logic                    device_req_o   [NrDevices],
    output logic [AddressWidth-1:0] device_addr_o  [NrDevices],
    output logic                    device_we_o    [NrDevices],
    output logic [DataWidth/8-1:0]  device_be_o    [NrDevices],
    output logic [DataWidth-1:0]    device_wdata_o [NrDevices],
    input  logic                    device_rvalid_i[NrDevices],
    input  logic [DataWidth-1:0]    device_rdata_i [NrDevices],
    input  logic                    device_err_i   [NrDevices],

    input  logic [AddressWidth-1:0] cfg_device_addr_base [NrDevices],
    input  logic [AddressWidth-1:0] cfg_device_addr_mask [NrDevices]
);
    localparam int HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;
    localparam int BeWidth  = DataWidth / 8;

`ifdef SIMPLE_BUS_DECERR_EN
    localparam logic DecErr = 1'b1;
`else
    localparam logic DecErr = 1'b0;
`endif

    logic                    host_found;
    logic [HostIdxW-1:0]     host_sel;
    logic [AddressWidth-1:0] win_addr;
    logic                    win_we;
    logic [BeWidth-1:0]      win_be;
    logic [DataWidth-1:0]    win_wdata;
    logic                    dev_found;
    logic [DevIdxW-1:0]      dev_sel;
    logic                    dev_hit;

    logic                    pend_reg, pend_next;
    logic [HostIdxW-1:0]     rsp_host_reg, rsp_host_next;
    logic [DevIdxW-1:0]      rsp_dev_reg, rsp_dev_next;
    logic                    rsp_unmapped_reg, rsp_unmapped_next;

    logic                    rsp_valid;
    logic [DataWidth-1:0]    rsp_rdata;
    logic                    rsp_err;

    // Descending scan so the lowest-index requester is the last (winning) assignment.
    always_comb begin
        host_found = 1'b0;
        host_sel   = '0;
        win_addr   = '0;
        win_we     = 1'b0;
        win_be     = '0;
        win_wdata  = '0;
        for (int i = NrHosts - 1; i >= 0; i--) begin
            if (host_req_i[i]) begin
                host_found = 1'b1;
                host_sel   = HostIdxW'(i);
                win_addr   = host_addr_i[i];
                win_we     = host_we_i[i];
                win_be     = host_be_i[i];
                win_wdata  = host_wdata_i[i];
            end
        end
    end

    always_comb begin
        dev_found = 1'b0;
        dev_sel   = '0;
        for (int d = NrDevices - 1; d >= 0; d--) begin
            if ((win_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) begin
                dev_found = 1'b1;
                dev_sel   = DevIdxW'(d);
            end
        end
    end

    assign dev_hit = host_found & dev_found;

    genvar gi;
    generate
        for (gi = 0; gi < NrDevices; gi++) begin : g_dev
            logic sel;
            assign sel               = dev_hit && (dev_sel == DevIdxW'(gi));
            assign device_req_o[gi]   = sel;
            assign device_addr_o[gi]  = sel ? win_addr  : '0;
            assign device_we_o[gi]    = sel ? win_we    : 1'b0;
            assign device_be_o[gi]    = sel ? win_be    : '0;
            assign device_wdata_o[gi] = sel ? win_wdata : '0;
        end
    endgenerate

    assign pend_next         = host_found;
    assign rsp_host_next     = host_sel;
    assign rsp_dev_next      = dev_sel;
    assign rsp_unmapped_next = ~dev_found;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_reg         <= 1'b0;
            rsp_host_reg     <= '0;
            rsp_dev_reg      <= '0;
            rsp_unmapped_reg <= 1'b0;
        end else begin
            pend_reg         <= pend_next;
            rsp_host_reg     <= rsp_host_next;
            rsp_dev_reg      <= rsp_dev_next;
            rsp_unmapped_reg <= rsp_unmapped_next;
        end
    end

    // Unmapped accesses are answered by the bus itself with zero data.
    always_comb begin
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        if (pend_reg) begin
            if (rsp_unmapped_reg) begin
                rsp_valid = 1'b1;
                rsp_err   = DecErr;
            end else begin
                for (int d = 0; d < NrDevices; d++) begin
                    if (rsp_dev_reg == DevIdxW'(d)) begin
                        rsp_valid = device_rvalid_i[d];
                        rsp_rdata = device_rdata_i[d];
                        rsp_err   = device_err_i[d];
                    end
                end
            end
        end
    end

    generate
        for (gi = 0; gi < NrHosts; gi++) begin : g_host
            logic own;
            assign own               = pend_reg && (rsp_host_reg == HostIdxW'(gi));
            assign host_gnt_o[gi]    = host_found && (host_sel == HostIdxW'(gi));
            assign host_rvalid_o[gi] = own & rsp_valid;
            assign host_rdata_o[gi]  = own ? rsp_rdata : '0;
            assign host_err_o[gi]    = own & rsp_err;
        end
    endgenerate

endmodule

// File: tb/tb_simple_bus.sv
// Scoreboard bench for simple_bus with two hosts and two devices; stimulus pushes expected
// responses, a negedge monitor pops and compares them.
module tb_simple_bus;
    localparam int NH = 2;
    localparam int ND = 2;

`ifdef SIMPLE_BUS_DECERR_EN
    localparam logic ExpDecErr = 1'b1;
`else
    localparam logic ExpDecErr = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        host_req    [NH];
    logic        host_gnt    [NH];
    logic [31:0] host_addr   [NH];
    logic        host_we     [NH];
    logic [3:0]  host_be     [NH];
    logic [31:0] host_wdata  [NH];
    logic        host_rvalid [NH];
    logic [31:0] host_rdata  [NH];
    logic        host_err    [NH];
    logic        dev_req     [ND];
    logic [31:0] dev_addr    [ND];
    logic        dev_we      [ND];
    logic [3:0]  dev_be      [ND];
    logic [31:0] dev_wdata   [ND];
    logic        dev_rvalid  [ND];
    logic [31:0] dev_rdata   [ND];
    logic        dev_err     [ND];
    logic [31:0] cfg_base    [ND];
    logic [31:0] cfg_mask    [ND];

    simple_bus #(.NrDevices(ND), .NrHosts(NH), .DataWidth(32), .AddressWidth(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .host_req_i(host_req), .host_gnt_o(host_gnt), .host_addr_i(host_addr),
        .host_we_i(host_we), .host_be_i(host_be), .host_wdata_i(host_wdata),
        .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
        .device_req_o(dev_req), .device_addr_o(dev_addr), .device_we_o(dev_we),
        .device_be_o(dev_be), .device_wdata_o(dev_wdata), .device_rvalid_i(dev_rvalid),
        .device_rdata_i(dev_rdata), .device_err_i(dev_err),
        .cfg_device_addr_base(cfg_base), .cfg_device_addr_mask(cfg_mask)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Device models: dev0 returns a constant, dev1 echoes the low address half and errors on 0x..EE.
    always_ff @(posedge clk) begin
        dev_rvalid[0] <= dev_req[0];
        dev_rdata[0]  <= dev_req[0] ? 32'hDEADBEEF : 32'h0;
        dev_err[0]    <= 1'b0;
        dev_rvalid[1] <= dev_req[1];
        dev_rdata[1]  <= dev_req[1] ? {16'h5A5A, dev_addr[1][15:0]} : 32'h0;
        dev_err[1]    <= dev_req[1] && (dev_addr[1][7:0] == 8'hEE);
    end

    typedef struct {
        int          host;
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int h, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.host = h; e.rdata = rdata; e.err = err; e.due = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        for (int h = 0; h < NH; h++) begin
            host_req[h] = 1'b0; host_addr[h] = '0; host_we[h] = 1'b0;
            host_be[h] = '0; host_wdata[h] = '0;
        end
    endtask

    task automatic drive(input int h, input logic [31:0] a, input logic we,
                         input logic [3:0] be, input logic [31:0] wd);
        host_req[h] = 1'b1; host_addr[h] = a; host_we[h] = we;
        host_be[h] = be; host_wdata[h] = wd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    // Monitor: one valid per cycle at most, each matched against the scoreboard head.
    always @(negedge clk) begin
        int nvalid;
        int vh;
        nvalid = 0;
        vh = 0;
        for (int h = 0; h < NH; h++) begin
            if (host_rvalid[h] === 1'b1) begin
                nvalid++;
                vh = h;
            end else if (host_rdata[h] !== 32'h0 || host_err[h] !== 1'b0) begin
                chk("idle_host_outputs_zero", {31'h0, host_err[h], host_rdata[h]}, 64'h0);
            end
        end
        if (nvalid > 1) begin
            chk("single_rvalid", 64'(nvalid), 64'd1);
        end else if (nvalid == 1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rvalid_host", 64'(vh), 64'hFFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("rsp host=%0d rdata=0x%08h err=%0b cycle=%0d", vh, host_rdata[vh], host_err[vh], cyc);
                chk("rsp_host", 64'(vh), 64'(e.host));
                chk("rsp_rdata", 64'(host_rdata[vh]), 64'(e.rdata));
                chk("rsp_err", 64'(host_err[vh]), 64'(e.err));
                chk("rsp_cycle", 64'(cyc), 64'(e.due));
            end
        end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("missing_rvalid_host", 64'hFFFF, 64'(e.host));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        cfg_base[0] = 32'h0010_0000; cfg_mask[0] = 32'hFFF0_0000;
        cfg_base[1] = 32'h0002_0000; cfg_mask[1] = 32'hFFFF_FC00;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_rvalid0", 64'(host_rvalid[0]), 64'd0);
        chk("reset_rvalid1", 64'(host_rvalid[1]), 64'd0);
        chk("reset_gnt0", 64'(host_gnt[0]), 64'd0);
        chk("reset_devreq0", 64'(dev_req[0]), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Read dev0
        step();
        drive(0, 32'h0010_0010, 1'b0, 4'hF, 32'h0);
        #3;
        $display("txn read host0 addr=0x00100010");
        chk("rd_gnt0", 64'(host_gnt[0]), 64'd1);
        chk("rd_gnt1", 64'(host_gnt[1]), 64'd0);
        chk("rd_devreq0", 64'(dev_req[0]), 64'd1);
        chk("rd_devreq1", 64'(dev_req[1]), 64'd0);
        chk("rd_devaddr0", 64'(dev_addr[0]), 64'h0010_0010);
        push(0, 32'hDEADBEEF, 1'b0);

        // Write dev1, back-to-back
        step();
        drive(0, 32'h0002_0004, 1'b1, 4'hF, 32'h41);
        #3;
        $display("txn write host0 addr=0x00020004 wdata=0x41");
        chk("wr_devreq1", 64'(dev_req[1]), 64'd1);
        chk("wr_devreq0", 64'(dev_req[0]), 64'd0);
        chk("wr_devaddr1", 64'(dev_addr[1]), 64'h0002_0004);
        chk("wr_devwe1", 64'(dev_we[1]), 64'd1);
        chk("wr_devbe1", 64'(dev_be[1]), 64'hF);
        chk("wr_devwdata1", 64'(dev_wdata[1]), 64'h41);
        chk("wr_devaddr0_zero", 64'(dev_addr[0]), 64'h0);
        push(0, 32'h5A5A_0004, 1'b0);

        // Two hosts contend: host0 wins, host1 follows
        step();
        drive(0, 32'h0010_0020, 1'b0, 4'hF, 32'h0);
        drive(1, 32'h0002_0008, 1'b0, 4'h3, 32'h0);
        #3;
        $display("txn contend host0 addr=0x00100020 host1 addr=0x00020008");
        chk("arb_gnt0", 64'(host_gnt[0]), 64'd1);
        chk("arb_gnt1", 64'(host_gnt[1]), 64'd0);
        chk("arb_devreq0", 64'(dev_req[0]), 64'd1);
        chk("arb_devreq1", 64'(dev_req[1]), 64'd0);
        push(0, 32'hDEADBEEF, 1'b0);
        step();
        drive(1, 32'h0002_0008, 1'b0, 4'h3, 32'h0);
        #3;
        $display("txn read host1 addr=0x00020008");
        chk("arb2_gnt1", 64'(host_gnt[1]), 64'd1);
        chk("arb2_gnt0", 64'(host_gnt[0]), 64'd0);
        chk("arb2_devbe1", 64'(dev_be[1]), 64'h3);
        push(1, 32'h5A5A_0008, 1'b0);

        // Device error routed to host1
        step();
        drive(1, 32'h0002_00EE, 1'b0, 4'hF, 32'h0);
        #3;
        $display("txn read host1 addr=0x000200EE (device error)");
        chk("derr_devreq1", 64'(dev_req[1]), 64'd1);
        push(1, 32'h5A5A_00EE, 1'b1);

        // Unmapped access
        step();
        drive(0, 32'h0, 1'b0, 4'hF, 32'h0);
        #3;
        $display("txn unmapped host0 addr=0x0");
        chk("unm_gnt0", 64'(host_gnt[0]), 64'd1);
        chk("unm_devreq0", 64'(dev_req[0]), 64'd0);
        chk("unm_devreq1", 64'(dev_req[1]), 64'd0);
        push(0, 32'h0, ExpDecErr);

        // Reset in the cycle after a grant discards the response
        step();
        drive(0, 32'h0010_0030, 1'b0, 4'hF, 32'h0);
        #3;
        $display("txn read host0 addr=0x00100030 then reset");
        chk("rst_gnt0", 64'(host_gnt[0]), 64'd1);
        step();
        rst = 1'b1;
        #3;
        chk("rst_rvalid0", 64'(host_rvalid[0]), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        step();
        drive(0, 32'h0010_0040, 1'b0, 4'hF, 32'h0);
        #3;
        $display("txn read host0 addr=0x00100040 after reset");
        chk("post_rst_gnt0", 64'(host_gnt[0]), 64'd1);
        chk("post_rst_devreq0", 64'(dev_req[0]), 64'd1);
        push(0, 32'hDEADBEEF, 1'b0);

        step();
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
